// File: rtl/calc_pkg.sv
// Shared types for the calculator sequencer: FSM states and the
// one-hot display-select encodings.
package calc_pkg;

  typedef enum logic [2:0] {
    ENTER_A,
    ENTER_B,
    ENTER_OP,
    EXEC,
    WAIT,
    SHOW,
    ERR
  } calc_state_t;

  // Bit order: {en_res, en_op, en_b, en_a}
  localparam logic [3:0] EN_NONE = 4'b0000;
  localparam logic [3:0] EN_A    = 4'b0001;
  localparam logic [3:0] EN_B    = 4'b0010;
  localparam logic [3:0] EN_OP   = 4'b0100;
  localparam logic [3:0] EN_RES  = 4'b1000;

  function automatic logic [3:0] en_of(
    input calc_state_t s
  );
    logic [3:0] e;
    e = EN_NONE;
    unique case (1'b1)
      s == ENTER_A:  e = EN_A;
      s == ENTER_B:  e = EN_B;
      s == ENTER_OP: e = EN_OP;
      s == SHOW:     e = EN_RES;
      default:       e = EN_NONE;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/calc_sequencer_if.sv
// Button/ALU control bundle between the calculator sequencer and
// its surroundings (buttons, operand registers, ALU, display mux).
interface calc_sequencer_if;

  logic progress;
  logic clear;
  logic alu_done;
  logic alu_err;
  logic ld_a;
  logic ld_b;
  logic ld_op;
  logic alu_start;
  logic en_a;
  logic en_b;
  logic en_op;
  logic en_res;
  logic busy;
  logic error;

  modport master (
    input  progress, clear,
    input  alu_done, alu_err,
    output ld_a, ld_b, ld_op,
    output alu_start,
    output en_a, en_b, en_op, en_res,
    output busy, error
  );

  modport slave (
    output progress, clear,
    output alu_done, alu_err,
    input  ld_a, ld_b, ld_op,
    input  alu_start,
    input  en_a, en_b, en_op, en_res,
    input  busy, error
  );

endinterface

// File: rtl/button_debounce.sv
// Level debouncer: dout follows din only after din has held a new
// value for CYCLES consecutive clocks.
module button_debounce #(
  parameter int CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic dout
);

  localparam int CW = $clog2(CYCLES + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= '0;
      dout <= 1'b0;
    end else if (din == dout) begin
      cnt  <= '0;
    end else if (cnt == CW'(CYCLES - 1)) begin
      cnt  <= '0;
      dout <= din;
    end else begin
      cnt  <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/calc_sequencer.sv
// Calculator control FSM: A / B / operator entry, ALU run, result.
// Define CALC_DEBOUNCE_EN to debounce the progress button.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int TIMEOUT         = 1024,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input logic              clk,
  input logic              reset_n,
  calc_sequencer_if.master bus
);

  localparam int CW = $clog2(TIMEOUT);

  calc_state_t   state;
  calc_state_t   state_d;
  logic          sync1;
  logic          sync2;
  logic          prog_s;
  logic          prog_q;
  logic          rel;
  logic          tmo;
  logic [CW-1:0] cnt;
  logic          ld_a_d;
  logic          ld_b_d;
  logic          ld_op_d;
  logic [3:0]    en_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      prog_q <= 1'b0;
    end else begin
      sync1  <= bus.progress;
      sync2  <= sync1;
      prog_q <= prog_s;
    end
  end

`ifdef CALC_DEBOUNCE_EN
  button_debounce #(
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (sync2),
    .dout    (prog_s)
  );
`else
  logic unused_cfg;
  assign unused_cfg = (DEBOUNCE_CYCLES > 0);
  assign prog_s     = sync2;
`endif

  assign rel = prog_q & ~prog_s;
  assign tmo = (cnt == CW'(TIMEOUT - 1));

  always_comb begin
    state_d = state;
    ld_a_d  = 1'b0;
    ld_b_d  = 1'b0;
    ld_op_d = 1'b0;
    if (bus.clear) begin
      state_d = ENTER_A;
    end else begin
      unique case (state)
        ENTER_A: if (rel) begin
          state_d = ENTER_B;
          ld_a_d  = 1'b1;
        end
        ENTER_B: if (rel) begin
          state_d = ENTER_OP;
          ld_b_d  = 1'b1;
        end
        ENTER_OP: if (rel) begin
          state_d = EXEC;
          ld_op_d = 1'b1;
        end
        EXEC: state_d = WAIT;
        WAIT: begin
          if (bus.alu_done)
            state_d = bus.alu_err ? ERR : SHOW;
          else if (tmo)
            state_d = ERR;
        end
        SHOW, ERR: if (rel) state_d = ENTER_A;
        default: state_d = ENTER_A;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ENTER_A;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= (state == WAIT) ? cnt + 1'b1 : '0;
    end
  end

  // alu_start launches off the EXEC state register, so it trails ld_op
  // by one cycle and the operator register is loaded before the ALU starts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.ld_a      <= 1'b0;
      bus.ld_b      <= 1'b0;
      bus.ld_op     <= 1'b0;
      bus.alu_start <= 1'b0;
      bus.busy      <= 1'b0;
      bus.error     <= 1'b0;
      en_q          <= EN_A;
    end else begin
      bus.ld_a      <= ld_a_d;
      bus.ld_b      <= ld_b_d;
      bus.ld_op     <= ld_op_d;
      bus.alu_start <= (state == EXEC) && !bus.clear;
      bus.busy      <= (state_d == EXEC) || (state_d == WAIT);
      bus.error     <= (state_d == ERR);
      en_q          <= en_of(state_d);
    end
  end

  assign bus.en_a   = en_q[0];
  assign bus.en_b   = en_q[1];
  assign bus.en_op  = en_q[2];
  assign bus.en_res = en_q[3];

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer (TIMEOUT=8, no debounce).
// Output vector: {ld_a,ld_b,ld_op,alu_start,en_a,en_b,en_op,en_res,busy,error}
module tb_calc_sequencer;

  localparam logic [9:0] O_A     = 10'h020;
  localparam logic [9:0] O_LDA   = 10'h210;
  localparam logic [9:0] O_B     = 10'h010;
  localparam logic [9:0] O_LDB   = 10'h108;
  localparam logic [9:0] O_OP    = 10'h008;
  localparam logic [9:0] O_EXEC  = 10'h082;
  localparam logic [9:0] O_START = 10'h042;
  localparam logic [9:0] O_WAIT  = 10'h002;
  localparam logic [9:0] O_SHOW  = 10'h004;
  localparam logic [9:0] O_ERR   = 10'h001;

  logic       clk;
  logic       reset_n;
  logic [9:0] outs;
  int         n_asserts;
  int         n_fail;

  calc_sequencer_if bus ();

  calc_sequencer #(
    .TIMEOUT (8)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  assign outs = {bus.ld_a, bus.ld_b, bus.ld_op,
                 bus.alu_start, bus.en_a, bus.en_b,
                 bus.en_op, bus.en_res, bus.busy,
                 bus.error};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [9:0] exp);
    logic [9:0] obs;
    obs = outs;
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic press(input string tag,
                       input logic [9:0] mid,
                       input logic [9:0] post);
    bus.progress = 1'b1;
    repeat (4) tick();
    bus.progress = 1'b0;
    tick();
    tick();
    chk({tag, "_mid"}, mid);
    tick();
    chk({tag, "_post"}, post);
  endtask

  task automatic do_entry(input string tag);
    press({tag, "_a"}, O_A, O_LDA);
    tick();
    chk({tag, "_b"}, O_B);
    press({tag, "_b"}, O_B, O_LDB);
    tick();
    chk({tag, "_op"}, O_OP);
    press({tag, "_op"}, O_OP, O_EXEC);
  endtask

  initial begin
    n_asserts    = 0;
    n_fail       = 0;
    reset_n      = 1'b1;
    bus.progress = 1'b0;
    bus.clear    = 1'b0;
    bus.alu_done = 1'b0;
    bus.alu_err  = 1'b0;
    #2 reset_n = 1'b0;
    repeat (3) tick();
    chk("reset_held", O_A);
    reset_n = 1'b1;
    tick();
    chk("reset_rel", O_A);

    // stray alu_done outside WAIT
    bus.alu_done = 1'b1;
    tick();
    bus.alu_done = 1'b0;
    chk("done_idle", O_A);

    // normal run, done on 5th WAIT cycle
    do_entry("run1");
    tick();
    chk("run1_w1", O_START);
    tick();
    chk("run1_w2", O_WAIT);
    repeat (3) tick();
    bus.alu_done = 1'b1;
    tick();
    bus.alu_done = 1'b0;
    chk("run1_show", O_SHOW);
    press("run1_ack", O_SHOW, O_A);

    // ALU error
    do_entry("run2");
    tick();
    bus.alu_done = 1'b1;
    bus.alu_err  = 1'b1;
    tick();
    bus.alu_done = 1'b0;
    bus.alu_err  = 1'b0;
    chk("run2_err", O_ERR);
    press("run2_ack", O_ERR, O_A);

    // timeout after exactly 8 WAIT cycles
    do_entry("run3");
    repeat (8) tick();
    chk("run3_w8", O_WAIT);
    tick();
    chk("run3_tmo", O_ERR);
    press("run3_ack", O_ERR, O_A);

    // done on the last WAIT cycle wins; release in WAIT ignored
    do_entry("run4");
    tick();
    bus.progress = 1'b1;
    tick();
    tick();
    bus.progress = 1'b0;
    tick();
    tick();
    chk("run4_w5", O_WAIT);
    tick();
    chk("run4_w6", O_WAIT);
    tick();
    tick();
    bus.alu_done = 1'b1;
    tick();
    bus.alu_done = 1'b0;
    chk("run4_show", O_SHOW);
    press("run4_ack", O_SHOW, O_A);

    // clear in ENTER_OP
    press("clr1_a", O_A, O_LDA);
    press("clr1_b", O_B, O_LDB);
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    chk("clr_op", O_A);

    // clear together with a release
    press("clr2_a", O_A, O_LDA);
    bus.progress = 1'b1;
    repeat (4) tick();
    bus.progress = 1'b0;
    tick();
    tick();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    chk("clr_rel", O_A);
    tick();
    chk("clr_rel2", O_A);

    // clear in WAIT
    do_entry("clr3");
    tick();
    tick();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    chk("clr_wait", O_A);
    tick();
    chk("clr_wait2", O_A);

    // reset mid-WAIT
    do_entry("rst");
    tick();
    tick();
    #2 reset_n = 1'b0;
    #1;
    chk("rst_async", O_A);
    tick();
    reset_n = 1'b1;
    tick();
    chk("rst_rel", O_A);
    tick();
    chk("rst_nostart", O_A);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asserts, n_fail);
    $finish;
  end

endmodule
